multi_counter_display: RTL and testbench
========================================

Name: multi_counter_display

Overview:
Parametrised bank of CHANNELS up/down counters with per-channel count enable, selective load, global clear, and a snapshot/display register stage. Snapshot registers are loaded from the counters on a capture pulse. Their contents are time-multiplexed onto a single display bus by an internal scan sequencer. The block serves as the next-generation counter/display front end for the board display path.

Parameters:
WIDTH, 8, counter and display data width in bits (>=2)
CHANNELS, 4, number of counter channels (>=2)
SAT, 0, boundary mode: 0 = wrap-around, 1 = saturate
SCAN_DIV, 4, clock cycles each channel is shown on dsp before advancing (>=1)
SELW (localparam), $clog2(CHANNELS), channel index width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-low
ci  in  CHANNELS  per-channel count enable, bit i enables channel i
up  in  1  count direction for all channels: 1 = increment, 0 = decrement
ld  in  1  load strobe for channel ld_sel
ld_sel  in  SELW  channel index to load
ld_val  in  WIDTH  load value
clr  in  1  clears all counters and boundary flags
cap  in  1  capture strobe, copies all counters into snapshot registers
hold  in  1  when 1, cap is ignored and snapshots are frozen
dsp  out  WIDTH  snapshot of channel dsp_sel
dsp_sel  out  SELW  channel currently presented on dsp
bflag  out  CHANNELS  sticky boundary flags, bit i set when channel i crosses max/0

Behaviour:
- Reset (rst=0 at an edge): all counters, snapshots, bflag, the scan divider, and dsp_sel go to 0; dsp therefore reads 0. Reset overrides every other input.
- Per-channel priority, evaluated each edge: clr > (ld and ld_sel==i) > ci[i] count > hold value.
- clr=1: every counter goes to 0 and bflag goes to all zeros, regardless of ld/ci.
- Load: the selected counter takes ld_val next cycle and its bflag bit clears. If ld_sel >= CHANNELS, the load is ignored and there is no side effect.
- Count up: cnt+1 mod 2^WIDTH.
  - At max (all ones), SAT=0 wraps to 0; SAT=1 stays at max.
  - In both modes bflag[i] is set and stays set until clr, a load of channel i, or reset.
- Count down: cnt-1.
  - At 0, SAT=0 wraps to max; SAT=1 stays at 0.
  - bflag[i] is set in both modes.
- Channels without ci set, not loaded and not cleared, hold their value.
- Capture: cap=1 and hold=0 at edge N puts the counter values present before edge N into all snapshots. Values written by a clr/ld/count on that same edge are not captured (one-cycle latency by design). With hold=1, cap has no effect.
- Snapshots are not affected by clr. Only reset or capture changes them.
- Scan sequencer: the divider counts 0..SCAN_DIV-1.
  - At the terminal count it returns to 0 and dsp_sel advances by 1.
  - dsp_sel wraps from CHANNELS-1 to 0. Non-power-of-two CHANNELS must never yield an out-of-range index.
  - After reset, dsp_sel=0 for SCAN_DIV cycles, then 1, and so on.
- dsp is a combinational mux: snapshot[dsp_sel]. Both operands are registered, so dsp changes only after clock edges.
- The scan runs continuously and independently of cap, hold, clr and ld.
- Reset mid-operation, including mid-scan-slot, restarts the scan at channel 0, divider 0.
- All arithmetic is unsigned and WIDTH bits wide. There is no carry out other than bflag.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> dsp=0, bflag=0; dsp_sel steps 0,1,2,3,0 every 4 cycles.
- Count/capture latency (WIDTH=8): ci=4'b0001, up=1 for 5 cycles from 0, cap on the 5th edge -> snapshot0=4 (pre-edge value), counter=5. A second cap gives 5; dsp=5 while dsp_sel=0.
- Wrap vs saturate: load channel1 with 8'hFE, count up 3 cycles.
  - SAT=0 -> 8'hFF, 8'h00, 8'h01, bflag[1]=1.
  - SAT=1 -> 8'hFF, 8'hFF, 8'hFF, bflag[1]=1.
  - Repeat down from 8'h01: SAT=0 reaches 8'hFF; SAT=1 stays 8'h00.
- Priority: clr=1, ld=1, ld_sel=2, ld_val=8'h55, ci=all ones on the same edge -> all counters 0, bflag=0. Next cycle ld alone -> channel2=8'h55, others 0.
- Hold and invalid select:
  - hold=1 with cap pulses while counting -> snapshots unchanged. Drop hold and pulse cap -> snapshots update.
  - CHANNELS=3, ld_sel=3 -> no counter changes.
  - dsp_sel sequence 0,1,2,0.
- Reset mid-operation: rst=0 while channel0=8'h20, dsp_sel=2, divider=1 -> next cycle all state 0, dsp_sel=0, scan restarts with a full SCAN_DIV slot.

Source files
------------

// File: rtl/multi_counter_display_if.sv
// Control and display bus of the counter bank: count/load/clear/capture controls in,
// scanned snapshot display and sticky boundary flags out.
interface multi_counter_display_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] ci;
    logic                up;
    logic                ld;
    logic [SELW-1:0]     ld_sel;
    logic [WIDTH-1:0]    ld_val;
    logic                clr;
    logic                cap;
    logic                hold;
    logic [WIDTH-1:0]    dsp;
    logic [SELW-1:0]     dsp_sel;
    logic [CHANNELS-1:0] bflag;

    // Controls are level-sampled on every rising clk edge; there is no handshake back-pressure.
    modport master (
        output ci, up, ld, ld_sel, ld_val, clr, cap, hold,
        input  dsp, dsp_sel, bflag
    );

    modport slave (
        input  ci, up, ld, ld_sel, ld_val, clr, cap, hold,
        output dsp, dsp_sel, bflag
    );
endinterface

// File: rtl/multi_counter_display.sv
// Bank of up/down counters with sticky boundary flags, a capture-on-strobe snapshot stage
// and a free-running scan that time-multiplexes the snapshots onto one display bus.
module multi_counter_display #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SAT      = 0,
    parameter int SCAN_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    multi_counter_display_if.slave bus
);
    localparam int SELW = $clog2(CHANNELS);
    localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
    localparam logic [SELW-1:0]  LAST_SEL = SELW'(CHANNELS - 1);
    localparam logic [DIVW-1:0]  LAST_DIV = DIVW'(SCAN_DIV - 1);

    logic [WIDTH-1:0]    cnt   [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    snap  [CHANNELS];
    logic [CHANNELS-1:0] bflag_q;
    logic [CHANNELS-1:0] bflag_d;
    logic [SELW-1:0]     sel_q;
    logic [DIVW-1:0]     div_q;
    logic                capture;

    assign capture = bus.cap & ~bus.hold;

    // Per-channel priority: clear, then load of this channel, then count, else hold.
    // An out-of-range ld_sel matches no channel, so that load simply has no effect.
    always_comb begin
        bflag_d = bflag_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt[i];
            if (bus.clr) begin
                cnt_d[i]   = '0;
                bflag_d[i] = 1'b0;
            end else if (bus.ld && (bus.ld_sel == SELW'(i))) begin
                cnt_d[i]   = bus.ld_val;
                bflag_d[i] = 1'b0;
            end else if (bus.ci[i]) begin
                if (bus.up) begin
                    if (cnt[i] == MAX) begin
                        bflag_d[i] = 1'b1;
                        cnt_d[i]   = (SAT != 0) ? MAX : '0;
                    end else begin
                        cnt_d[i] = cnt[i] + WIDTH'(1);
                    end
                end else begin
                    if (cnt[i] == '0) begin
                        bflag_d[i] = 1'b1;
                        cnt_d[i]   = (SAT != 0) ? '0 : MAX;
                    end else begin
                        cnt_d[i] = cnt[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    // Snapshots take the pre-edge counter values; clr does not touch them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i]  <= '0;
                snap[i] <= '0;
            end
            bflag_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= cnt_d[i];
                if (capture) begin
                    snap[i] <= cnt[i];
                end
            end
            bflag_q <= bflag_d;
        end
    end

    // Scan runs regardless of every control except reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q <= '0;
            sel_q <= '0;
        end else if (div_q == LAST_DIV) begin
            div_q <= '0;
            sel_q <= (sel_q == LAST_SEL) ? '0 : sel_q + SELW'(1);
        end else begin
            div_q <= div_q + DIVW'(1);
        end
    end

    assign bus.dsp     = snap[sel_q];
    assign bus.dsp_sel = sel_q;
    assign bus.bflag   = bflag_q;
endmodule

// File: tb/tb_multi_counter_display.sv
// Bench for multi_counter_display: three instances (4-ch wrap, 4-ch saturate, 3-ch wrap)
// share one stimulus stream and are compared to a behavioural model of the counter rules.
module tb_multi_counter_display;
    localparam int SD = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] ci     = '0;
    logic       up     = 1'b0;
    logic       ld     = 1'b0;
    logic [1:0] ld_sel = '0;
    logic [7:0] ld_val = '0;
    logic       clr    = 1'b0;
    logic       cap    = 1'b0;
    logic       hold   = 1'b0;

    always #5 clk = ~clk;

    multi_counter_display_if #(.WIDTH(8), .CHANNELS(4)) bus_w ();
    multi_counter_display_if #(.WIDTH(8), .CHANNELS(4)) bus_s ();
    multi_counter_display_if #(.WIDTH(8), .CHANNELS(3)) bus_3 ();

    assign bus_w.ci = ci;       assign bus_s.ci = ci;       assign bus_3.ci = ci[2:0];
    assign bus_w.up = up;       assign bus_s.up = up;       assign bus_3.up = up;
    assign bus_w.ld = ld;       assign bus_s.ld = ld;       assign bus_3.ld = ld;
    assign bus_w.ld_sel = ld_sel; assign bus_s.ld_sel = ld_sel; assign bus_3.ld_sel = ld_sel;
    assign bus_w.ld_val = ld_val; assign bus_s.ld_val = ld_val; assign bus_3.ld_val = ld_val;
    assign bus_w.clr = clr;     assign bus_s.clr = clr;     assign bus_3.clr = clr;
    assign bus_w.cap = cap;     assign bus_s.cap = cap;     assign bus_3.cap = cap;
    assign bus_w.hold = hold;   assign bus_s.hold = hold;   assign bus_3.hold = hold;

    multi_counter_display #(.WIDTH(8), .CHANNELS(4), .SAT(0), .SCAN_DIV(SD)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w));
    multi_counter_display #(.WIDTH(8), .CHANNELS(4), .SAT(1), .SCAN_DIV(SD)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s));
    multi_counter_display #(.WIDTH(8), .CHANNELS(3), .SAT(0), .SCAN_DIV(SD)) dut_3 (
        .clk(clk), .rst(rst), .bus(bus_3));

    // Reference model: plain integer counters per instance.
    int nch [3] = '{4, 4, 3};
    int sat [3] = '{0, 1, 0};
    int m_cnt  [3][4];
    int m_snap [3][4];
    bit m_bf   [3][4];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void model_edge();
        if (rst == 1'b0) begin
            for (int c = 0; c < 3; c++)
                for (int i = 0; i < 4; i++) begin
                    m_cnt[c][i] = 0; m_snap[c][i] = 0; m_bf[c][i] = 1'b0;
                end
            cyc = 0;
            return;
        end
        cyc++;
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < nch[c]; i++) begin
                if (cap && !hold) m_snap[c][i] = m_cnt[c][i];
                if (clr) begin
                    m_cnt[c][i] = 0; m_bf[c][i] = 1'b0;
                end else if (ld && int'(ld_sel) == i) begin
                    m_cnt[c][i] = int'(ld_val); m_bf[c][i] = 1'b0;
                end else if (ci[i]) begin
                    if (up) begin
                        if (m_cnt[c][i] == 255) begin
                            m_bf[c][i] = 1'b1;
                            m_cnt[c][i] = (sat[c] != 0) ? 255 : 0;
                        end else m_cnt[c][i] = m_cnt[c][i] + 1;
                    end else begin
                        if (m_cnt[c][i] == 0) begin
                            m_bf[c][i] = 1'b1;
                            m_cnt[c][i] = (sat[c] != 0) ? 0 : 255;
                        end else m_cnt[c][i] = m_cnt[c][i] - 1;
                    end
                end
            end
    endfunction

    function automatic int exp_sel(int c);
        return (cyc / SD) % nch[c];
    endfunction

    function automatic logic [7:0] exp_dsp(int c);
        return 8'(m_snap[c][exp_sel(c)]);
    endfunction

    function automatic logic [3:0] exp_bf(int c);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < nch[c]; i++) v[i] = m_bf[c][i];
        return v;
    endfunction

    function automatic logic [7:0] obs_dsp(int c);
        case (c)
            0:       return bus_w.dsp;
            1:       return bus_s.dsp;
            default: return bus_3.dsp;
        endcase
    endfunction

    function automatic logic [1:0] obs_sel(int c);
        case (c)
            0:       return bus_w.dsp_sel;
            1:       return bus_s.dsp_sel;
            default: return bus_3.dsp_sel;
        endcase
    endfunction

    function automatic logic [3:0] obs_bf(int c);
        case (c)
            0:       return bus_w.bflag;
            1:       return bus_s.bflag;
            default: return {1'b0, bus_3.bflag};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_sel(int c, int t);
        for (int k = 0; k < 20 && exp_sel(c) != t; k++) tick();
    endtask

    task automatic idle_inputs();
        ci = '0; up = 1'b0; ld = 1'b0; ld_sel = '0; ld_val = '0;
        clr = 1'b0; cap = 1'b0; hold = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick(); tick();
        for (int c = 0; c < 3; c++) begin
            n_cmp += 3;
            if (obs_dsp(c) !== 8'h00) begin n_bad++; $display("FAIL reset_dsp dut%0d: got %0h want 0", c, obs_dsp(c)); end
            if (obs_sel(c) !== 2'd0) begin n_bad++; $display("FAIL reset_sel dut%0d: got %0d want 0", c, obs_sel(c)); end
            if (obs_bf(c) !== 4'h0) begin n_bad++; $display("FAIL reset_bflag dut%0d: got %0h want 0", c, obs_bf(c)); end
        end
        rst = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp += 2;
                if (obs_sel(c) !== 2'((k / SD) % nch[c])) begin
                    n_bad++; $display("FAIL idle_scan dut%0d k%0d: got %0d want %0d", c, k, obs_sel(c), (k / SD) % nch[c]);
                end
                if (obs_dsp(c) !== 8'h00) begin n_bad++; $display("FAIL idle_dsp dut%0d: got %0h want 0", c, obs_dsp(c)); end
            end
        end
    endtask

    task automatic test_count_capture();
        idle_inputs();
        up = 1'b1; ci = 4'b0001;
        repeat (4) tick();
        cap = 1'b1;
        tick();
        cap = 1'b0; ci = '0;
        for (int c = 0; c < 3; c++) begin
            wait_sel(c, 0);
            n_cmp++;
            if (obs_dsp(c) !== 8'h04) begin n_bad++; $display("FAIL cap_latency dut%0d: got %0h want 04", c, obs_dsp(c)); end
        end
        cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wait_sel(c, 0);
            n_cmp++;
            if (obs_dsp(c) !== 8'h05) begin n_bad++; $display("FAIL cap_second dut%0d: got %0h want 05", c, obs_dsp(c)); end
        end
    endtask

    task automatic test_wrap_sat();
        logic [7:0] up_wrap [3] = '{8'hFF, 8'h00, 8'h01};
        logic [7:0] up_sat  [3] = '{8'hFF, 8'hFF, 8'hFF};
        logic [7:0] dn_wrap [2] = '{8'h00, 8'hFF};
        logic [7:0] dn_sat  [2] = '{8'h00, 8'h00};
        logic [3:0] b;
        logic [7:0] want;
        for (int dir = 1; dir >= 0; dir--) begin
            idle_inputs();
            ld = 1'b1; ld_sel = 2'd1; ld_val = (dir == 1) ? 8'hFE : 8'h01;
            tick();
            ld = 1'b0;
            for (int c = 0; c < 3; c++) begin
                b = obs_bf(c);
                n_cmp++;
                if (b[1] !== 1'b0) begin n_bad++; $display("FAIL load_clears_bflag dut%0d dir%0d: got %0b want 0", c, dir, b[1]); end
            end
            up = dir[0];
            for (int s = 0; s < ((dir == 1) ? 3 : 2); s++) begin
                ci = 4'b0010; tick(); ci = '0;
                cap = 1'b1; tick(); cap = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    wait_sel(c, 1);
                    if (dir == 1) want = (sat[c] != 0) ? up_sat[s] : up_wrap[s];
                    else          want = (sat[c] != 0) ? dn_sat[s] : dn_wrap[s];
                    n_cmp++;
                    if (obs_dsp(c) !== want) begin
                        n_bad++; $display("FAIL boundary dut%0d dir%0d step%0d: got %0h want %0h", c, dir, s, obs_dsp(c), want);
                    end
                end
            end
            for (int c = 0; c < 3; c++) begin
                b = obs_bf(c);
                n_cmp++;
                if (b[1] !== 1'b1) begin n_bad++; $display("FAIL bflag_set dut%0d dir%0d: got %0b want 1", c, dir, b[1]); end
            end
        end
    endtask

    task automatic test_priority();
        idle_inputs();
        clr = 1'b1; ld = 1'b1; ld_sel = 2'd2; ld_val = 8'h55; ci = 4'hF; up = 1'b1;
        tick();
        clr = 1'b0; ci = '0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (obs_bf(c) !== 4'h0) begin n_bad++; $display("FAIL clr_bflag dut%0d: got %0h want 0", c, obs_bf(c)); end
        end
        cap = 1'b1;
        tick();
        ld = 1'b0; cap = 1'b0;
        for (int c = 0; c < 3; c++)
            for (int t = 0; t < nch[c]; t++) begin
                wait_sel(c, t);
                n_cmp++;
                if (obs_dsp(c) !== 8'h00) begin n_bad++; $display("FAIL clr_wins dut%0d ch%0d: got %0h want 0", c, t, obs_dsp(c)); end
            end
        cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int c = 0; c < 3; c++)
            for (int t = 0; t < nch[c]; t++) begin
                wait_sel(c, t);
                n_cmp++;
                if (obs_dsp(c) !== ((t == 2) ? 8'h55 : 8'h00)) begin
                    n_bad++; $display("FAIL load_after_clr dut%0d ch%0d: got %0h want %0h", c, t, obs_dsp(c), (t == 2) ? 8'h55 : 8'h00);
                end
            end
    endtask

    task automatic test_hold_invalid();
        idle_inputs();
        ci = 4'hF; up = 1'b1; hold = 1'b1; cap = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (obs_dsp(c) !== ((exp_sel(c) == 2) ? 8'h55 : 8'h00)) begin
                    n_bad++; $display("FAIL hold_frozen dut%0d k%0d: got %0h want %0h", c, k, obs_dsp(c), (exp_sel(c) == 2) ? 8'h55 : 8'h00);
                end
            end
        end
        hold = 1'b0;
        tick();
        cap = 1'b0; ci = '0;
        ld = 1'b1; ld_sel = 2'd3; ld_val = 8'hAA;
        tick();
        ld = 1'b0; cap = 1'b1;
        tick();
        cap = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 3; c++) begin
                n_cmp += 2;
                if (obs_dsp(c) !== exp_dsp(c)) begin
                    n_bad++; $display("FAIL release_invalid_dsp dut%0d k%0d: got %0h want %0h", c, k, obs_dsp(c), exp_dsp(c));
                end
                if (obs_sel(c) !== 2'(exp_sel(c))) begin
                    n_bad++; $display("FAIL scan_seq dut%0d k%0d: got %0d want %0d", c, k, obs_sel(c), exp_sel(c));
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        ld = 1'b1; ld_sel = 2'd0; ld_val = 8'h20; tick();
        ld_sel = 2'd1; ld_val = 8'hFF; tick();
        ld = 1'b0; ci = 4'b0010; up = 1'b1; tick();
        ci = '0; cap = 1'b1; tick();
        cap = 1'b0;
        for (int k = 0; k < 40 && !(exp_sel(0) == 2 && (cyc % SD) == 1); k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_cmp += 3;
            if (obs_sel(c) !== 2'd0) begin n_bad++; $display("FAIL midrst_sel dut%0d: got %0d want 0", c, obs_sel(c)); end
            if (obs_dsp(c) !== 8'h00) begin n_bad++; $display("FAIL midrst_dsp dut%0d: got %0h want 0", c, obs_dsp(c)); end
            if (obs_bf(c) !== 4'h0) begin n_bad++; $display("FAIL midrst_bflag dut%0d: got %0h want 0", c, obs_bf(c)); end
        end
        for (int k = 1; k <= SD; k++) begin
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp++;
                if (obs_sel(c) !== ((k == SD) ? 2'd1 : 2'd0)) begin
                    n_bad++; $display("FAIL midrst_slot dut%0d k%0d: got %0d want %0d", c, k, obs_sel(c), (k == SD) ? 1 : 0);
                end
            end
        end
        cap = 1'b1; tick(); cap = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wait_sel(c, 0);
            n_cmp++;
            if (obs_dsp(c) !== 8'h00) begin n_bad++; $display("FAIL midrst_cnt dut%0d: got %0h want 0", c, obs_dsp(c)); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst    = ($urandom_range(0, 99) != 0);
            ci     = 4'($urandom_range(0, 15));
            up     = 1'($urandom_range(0, 1));
            ld     = ($urandom_range(0, 5) == 0);
            ld_sel = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0:       ld_val = 8'h00;
                1:       ld_val = 8'h01;
                2:       ld_val = 8'hFE;
                3:       ld_val = 8'hFF;
                default: ld_val = 8'($urandom_range(0, 255));
            endcase
            clr  = ($urandom_range(0, 29) == 0);
            cap  = ($urandom_range(0, 3) == 0);
            hold = ($urandom_range(0, 2) == 0);
            tick();
            for (int c = 0; c < 3; c++) begin
                n_cmp += 3;
                if (obs_dsp(c) !== exp_dsp(c)) begin
                    n_bad++; $display("FAIL rand_dsp dut%0d k%0d: got %0h want %0h", c, k, obs_dsp(c), exp_dsp(c));
                end
                if (obs_sel(c) !== 2'(exp_sel(c))) begin
                    n_bad++; $display("FAIL rand_sel dut%0d k%0d: got %0d want %0d", c, k, obs_sel(c), exp_sel(c));
                end
                if (obs_bf(c) !== exp_bf(c)) begin
                    n_bad++; $display("FAIL rand_bflag dut%0d k%0d: got %0h want %0h", c, k, obs_bf(c), exp_bf(c));
                end
            end
        end
        rst = 1'b1;
        idle_inputs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_count_capture();
        test_wrap_sat();
        test_priority();
        test_hold_invalid();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
